// File: rtl/fp_subtractor_seq.sv
// Multi-cycle single-precision subtractor: result = A - B.
// Bit-serial alignment and normalization, truncating datapath, FTZ.
module fp_subtractor_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     A,
    input  logic [EXP_W+MAN_W:0]     B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     invalid
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int CW = $clog2(SW + 2);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic [EXP_W-1:0] SH_CAP   = EXP_W'(SW + 1);
    localparam logic [CW-1:0]    CNT_CAP  = CW'(SW + 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [W-1:0]     QNAN     =
        {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [SW-1:0]    r_x;
    logic [SW-1:0]    r_y;
    logic [SW:0]      r_sum;
    logic [EXP_W-1:0] r_exp;
    logic             r_sign;
    logic             r_sub;
    logic             r_spec;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_res;
    logic             r_ovf;
    logic             r_udf;
    logic             r_inv;

    logic [EXP_W-1:0] w_ea;
    logic [EXP_W-1:0] w_eb;
    logic [MAN_W-1:0] w_ma;
    logic [MAN_W-1:0] w_mb;
    logic [SW-1:0]    w_siga;
    logic [SW-1:0]    w_sigb;
    logic             w_spec;
    logic             w_a_ge;
    logic [EXP_W-1:0] w_d;
    logic [CW-1:0]    w_cnt;

    logic             w_sum_zero;
    logic             w_carry;
    logic             w_top;
    logic             w_exp_low;
    logic             w_norm_exit;
    logic [EXP_W-1:0] w_exp_inc;
    logic [EXP_W-1:0] w_exp_dec;

    // Operand classification and magnitude ordering from latched operands
    assign w_ea   = r_a[W-2:MAN_W];
    assign w_eb   = r_b[W-2:MAN_W];
    assign w_ma   = r_a[MAN_W-1:0];
    assign w_mb   = r_b[MAN_W-1:0];
    assign w_spec = (w_ea == EXP_ONES) || (w_eb == EXP_ONES);
    assign w_siga = (w_ea == '0) ? '0 : {1'b1, w_ma};
    assign w_sigb = (w_eb == '0) ? '0 : {1'b1, w_mb};
    assign w_a_ge = (r_a[W-2:0] >= r_b[W-2:0]);
    assign w_d    = w_a_ge ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_cnt  = (w_d > SH_CAP) ? CNT_CAP : w_d[CW-1:0];

    // Normalization decisions for the current sum
    assign w_sum_zero  = (r_sum == '0);
    assign w_carry     = r_sum[SW];
    assign w_top       = r_sum[SW-1];
    assign w_exp_low   = (r_exp <= EXP_ONE);
    assign w_exp_inc   = r_exp + EXP_ONE;
    assign w_exp_dec   = r_exp - EXP_ONE;
    assign w_norm_exit = r_spec || w_sum_zero || w_carry || w_top ||
                         w_exp_low || r_sum[SW-2];

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_res;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
    assign invalid   = r_inv;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (w_spec) begin
                    w_next = S_NORM;
                end else if (w_cnt == '0) begin
                    w_next = S_ADD;
                end else begin
                    w_next = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (r_cnt == CNT_ONE) begin
                    w_next = S_ADD;
                end
            end
            S_ADD: begin
                w_next = S_NORM;
            end
            S_NORM: begin
                if (w_norm_exit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: unpack, serial align, add, serial normalize, pack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_sum  <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
            r_sub  <= 1'b0;
            r_spec <= 1'b0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
            r_inv  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= A;
                        r_b <= B;
                    end
                end
                S_UNPACK: begin
                    r_spec <= w_spec;
                    r_sub  <= (r_a[W-1] == r_b[W-1]);
                    r_sign <= w_a_ge ? r_a[W-1] : ~r_b[W-1];
                    r_x    <= w_a_ge ? w_siga : w_sigb;
                    r_y    <= w_a_ge ? w_sigb : w_siga;
                    r_exp  <= w_a_ge ? w_ea : w_eb;
                    r_cnt  <= w_cnt;
                end
                S_ALIGN: begin
                    r_y   <= r_y >> 1;
                    r_cnt <= r_cnt - CNT_ONE;
                end
                S_ADD: begin
                    if (r_sub) begin
                        r_sum <= {1'b0, r_x} - {1'b0, r_y};
                    end else begin
                        r_sum <= {1'b0, r_x} + {1'b0, r_y};
                    end
                end
                S_NORM: begin
                    if (r_spec) begin
                        r_res <= QNAN;
                        r_inv <= 1'b1;
                    end else if (w_sum_zero) begin
                        r_res <= '0;
                    end else if (w_carry) begin
                        if (w_exp_inc == EXP_ONES) begin
                            r_res <= {r_sign, EXP_ONES, {MAN_W{1'b0}}};
                            r_ovf <= 1'b1;
                        end else begin
                            r_res <= {r_sign, w_exp_inc, r_sum[MAN_W:1]};
                        end
                    end else if (w_top) begin
                        r_res <= {r_sign, r_exp, r_sum[MAN_W-1:0]};
                    end else if (w_exp_low) begin
                        r_res <= '0;
                        r_udf <= 1'b1;
                    end else begin
                        r_sum <= r_sum << 1;
                        r_exp <= w_exp_dec;
                        if (r_sum[SW-2]) begin
                            r_res <= {r_sign, w_exp_dec,
                                      r_sum[MAN_W-2:0], 1'b0};
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_ovf <= 1'b0;
                        r_udf <= 1'b0;
                        r_inv <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Directed bench for fp_subtractor_seq: results, flags, latency,
// backpressure and mid-operation reset.
module tb_fp_subtractor_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    int checks;
    int errors;

    fp_subtractor_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation; lat = edges after the accept edge until
    // out_valid is seen, or -1 if it never rises within the budget.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_hs got rdy/vld=%b expected 10",
                     {in_ready, out_valid});
        end
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result got %h expected 00000000", result);
        end
        checks++;
        if ({overflow, underflow, invalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000",
                     {overflow, underflow, invalid});
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va  [10];
        logic [31:0] vb  [10];
        logic [31:0] vr  [10];
        logic [2:0]  vf  [10];
        int          vl  [10];
        int          lat;
        // {ovf,udf,inv}
        va[0] = 32'h40400000; vb[0] = 32'h3F800000;
        vr[0] = 32'h40000000; vf[0] = 3'b000; vl[0] = 4;
        va[1] = 32'h3F800000; vb[1] = 32'h3F800000;
        vr[1] = 32'h00000000; vf[1] = 3'b000; vl[1] = 3;
        va[2] = 32'h3F800000; vb[2] = 32'hBF800000;
        vr[2] = 32'h40000000; vf[2] = 3'b000; vl[2] = 3;
        va[3] = 32'h3F800000; vb[3] = 32'h3FC00000;
        vr[3] = 32'hBF000000; vf[3] = 3'b000; vl[3] = 3;
        va[4] = 32'h3F800000; vb[4] = 32'h30800000;
        vr[4] = 32'h3F800000; vf[4] = 3'b000; vl[4] = 28;
        va[5] = 32'h7F7FFFFF; vb[5] = 32'hFF7FFFFF;
        vr[5] = 32'h7F800000; vf[5] = 3'b100; vl[5] = 3;
        va[6] = 32'h00800001; vb[6] = 32'h00800000;
        vr[6] = 32'h00000000; vf[6] = 3'b010; vl[6] = 3;
        va[7] = 32'h7F800000; vb[7] = 32'h3F800000;
        vr[7] = 32'h7FC00000; vf[7] = 3'b001; vl[7] = 2;
        va[8] = 32'h40A00000; vb[8] = 32'h40400000;
        vr[8] = 32'h40000000; vf[8] = 3'b000; vl[8] = 4;
        va[9] = 32'h3F800000; vb[9] = 32'h3F7FFFFF;
        vr[9] = 32'h34000000; vf[9] = 3'b000; vl[9] = 26;
        for (int i = 0; i < 10; i++) begin
            do_op(va[i], vb[i], lat);
            checks++;
            if (lat !== vl[i]) begin
                errors++;
                $display("FAIL vec%0d_latency got %0d expected %0d",
                         i, lat, vl[i]);
            end
            checks++;
            if (result !== vr[i]) begin
                errors++;
                $display("FAIL vec%0d_result got %h expected %h",
                         i, result, vr[i]);
            end
            checks++;
            if ({overflow, underflow, invalid} !== vf[i]) begin
                errors++;
                $display("FAIL vec%0d_flags got %b expected %b", i,
                         {overflow, underflow, invalid}, vf[i]);
            end
            handoff();
            checks++;
            if ({in_ready, out_valid, overflow, underflow, invalid}
                    !== 5'b10000) begin
                errors++;
                $display("FAIL vec%0d_handoff got %b expected 10000", i,
                         {in_ready, out_valid, overflow, underflow,
                          invalid});
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(32'h40400000, 32'h3F800000, lat);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first got out_valid=%b expected 1",
                     out_valid);
        end
        // second request held high while the first result waits
        A        = 32'h3F800000;
        B        = 32'h3FC00000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, result} !==
                {1'b1, 1'b0, 32'h40000000}) begin
                errors++;
                $display("FAIL bp_hold%0d got v/r/res=%b/%b/%h expected 1/0/40000000",
                         i, out_valid, in_ready, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_after_handoff got rdy/vld=%b expected 10",
                     {in_ready, out_valid});
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept got in_ready=%b expected 0",
                     in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if ({out_valid, result} !== {1'b1, 32'hBF000000} || lat !== 3) begin
            errors++;
            $display("FAIL bp_second_result got v=%b res=%h lat=%0d expected 1 BF000000 3",
                     out_valid, result, lat);
        end
        handoff();
    endtask

    task automatic test_reset_mid_align();
        int lat;
        @(negedge clk);
        A        = 32'h3F800000;
        B        = 32'h30800000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, overflow, underflow, invalid}
                !== 5'b10000) begin
            errors++;
            $display("FAIL midrst_state got %b expected 10000",
                     {in_ready, out_valid, overflow, underflow, invalid});
        end
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL midrst_result got %h expected 00000000", result);
        end
        do_op(32'h40400000, 32'h3F800000, lat);
        checks++;
        if (result !== 32'h40000000 || lat !== 4) begin
            errors++;
            $display("FAIL midrst_rerun got res=%h lat=%0d expected 40000000 4",
                     result, lat);
        end
        handoff();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 32'h0;
        B         = 32'h0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_subtractor_seq.md
Name: fp_subtractor_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor; computes result = A - B.
- It is the complement of the team's combinational adder path:
  - handles sign, effective subtraction, and left (leading-zero) normalization;
  - takes operands through a valid/ready handshake;
  - shifts one bit per cycle in its alignment and normalization stages.
- Sits beside the adder in the FP datapath.
- One operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width (hidden bit excluded).
- Total word width is 1+EXP_W+MAN_W. All values below assume the defaults.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands A/B valid
- in_ready  out  1  block can accept; high only in IDLE
- A  in  32  minuend, IEEE-754 single
- B  in  32  subtrahend, IEEE-754 single
- out_valid  out  1  result valid; held until consumed
- out_ready  in  1  consumer accepts result
- result  out  32  A - B
- overflow  out  1  result saturated to infinity
- underflow  out  1  nonzero result flushed to zero
- invalid  out  1  an operand had exponent all-ones; result is canonical NaN

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; overflow/underflow/invalid=0. A reset in any state, including mid-ALIGN/NORM or while DONE waits, aborts the operation with no output.
- Accept: on an edge with in_valid&&in_ready (edge k), A/B are latched and the FSM moves to UNPACK.
- UNPACK (1 cycle):
  - Classify operands: exp==0 means zero (denormals flushed, FTZ); exp==255 sets invalid and goes straight to DONE with result 0x7FC00000.
  - Otherwise form 24-bit significands with the hidden bit.
  - Effective op is SUB if sign(A)==sign(B), else ADD.
  - Order by magnitude {exp,man}: X = larger, Y = smaller.
  - Result sign: sign(A) if |A|>=|B|, else ~sign(B).
  - d = expX - expY.
  - A zero operand is a significand of 0; no shortcut path.
- ALIGN: Y shifts right 1 bit per cycle, s = min(d,25) cycles; state skipped when d==0. Shifted-out bits are discarded (no guard/round/sticky). Truncated datapath, not IEEE round-to-nearest.
- ADD (1 cycle): 25-bit sum = X+Y or X-Y; X>=Y, so no negative difference.
- NORM: occupies m = max(1,n) cycles, one action per cycle:
  - sum==0: result = +0 (0x00000000), exit.
  - carry bit set: shift right 1, exp+1. If exp reaches 255: result = sign|0x7F800000, overflow=1, exit.
  - bit23==0: shift left 1, exp-1. If exp would drop below 1: result = +0, underflow=1, exit.
  - bit23==1: pack result, exit.
- DONE:
  - out_valid=1; result and flags held stable.
  - On an edge with out_ready: out_valid=0, flags clear, go to IDLE (in_ready=1 the next cycle).
  - No accept in the same cycle as the result handoff.
- Latency: out_valid is high after edge k+2+s+m. The special-operand path reaches DONE after edge k+2.
- Inputs A/B are ignored while in_ready=0. in_valid held high across busy cycles is accepted only on return to IDLE.

Test Plan:
- A=0x40400000 (3.0), B=0x3F800000 (1.0) -> result 0x40000000, flags 0; s=1, m=1, out_valid after edge k+4.
- A=0x3F800000, B=0x3F800000 -> result 0x00000000, no flags; out_valid after edge k+3. A=0x3F800000, B=0xBF800000 -> 0x40000000 via carry right-shift, k+3.
- A=0x3F800000 (1.0), B=0x3FC00000 (1.5) -> 0xBF000000 (-0.5); one left shift. A=0x3F800000, B=0x30800000 (d=30, s capped at 25) -> 0x3F800000.
- A=0x7F7FFFFF, B=0xFF7FFFFF -> 0x7F800000, overflow=1. A=0x00800001, B=0x00800000 -> 0x00000000, underflow=1. A=0x7F800000, any B -> 0x7FC00000, invalid=1, out_valid after edge k+2.
- Backpressure: out_ready low 5 cycles in DONE -> result, flags and out_valid stable; in_ready=0 throughout; a second in_valid is not accepted until the cycle after the handoff.
- Reset: assert rst for 1 cycle during ALIGN of the d=30 case -> next cycle state IDLE, in_ready=1, out_valid=0; a fresh 3.0-1.0 then completes normally with 0x40000000.
